// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port synchronous RAM between the instruction
// fetch port and the load/store data port. One grant per cycle, combinational
// grant path, registered owner so the acknowledge lands exactly one cycle later.
// Data normally has priority; a bounded burst counter forces a waiting fetch
// through after MAX_DATA_BURST consecutive data grants.
// Optional build macro: MEM_ARB_STATS_EN adds the stat_if_stall counter port.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // instruction fetch port
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ack,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  // load/store data port
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_ack,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  // RAM side
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]             stat_if_stall
`endif
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // Owner of the access currently in flight in the RAM
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  // Burst limit held in the counter's own width (limit is at most 15)
  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  logic [1:0] owner_reg, owner_next;
  logic       if_pend_reg, if_pend_next;
  logic       d_pend_reg, d_pend_next;
  logic       store_reg, store_next;
  logic [3:0] burst_reg, burst_next;

  logic if_elig;
  logic d_elig;
  logic fetch_forced;
  logic grant_if;
  logic grant_d;
  logic grant_store;

  // ---------------------------------------------------------------------------
  // Acknowledge decode: the owner register names the port whose access was
  // granted last cycle, so its ack and read data appear now.
  // ---------------------------------------------------------------------------
  assign if_ack   = (owner_reg == OWN_IF);
  assign d_ack    = (owner_reg == OWN_DATA);
  assign if_rdata = if_ack ? mem_rdata : '0;
  // A store acknowledge carries no data
  assign d_rdata  = (d_ack && !store_reg) ? mem_rdata : '0;

  // ---------------------------------------------------------------------------
  // Eligibility and priority. A port with an access in flight may issue again
  // in its own ack cycle, which allows back-to-back accesses.
  // Grants are suppressed while rst is high so the RAM sees no activity.
  // ---------------------------------------------------------------------------
  assign if_elig      = if_req && (!if_pend_reg || if_ack);
  assign d_elig       = d_req  && (!d_pend_reg  || d_ack);
  assign fetch_forced = (burst_reg == BURST_MAX) && if_elig;
  assign grant_d      = !rst && d_elig && !fetch_forced;
  assign grant_if     = !rst && if_elig && !grant_d;
  assign grant_store  = grant_d && d_we;

  // ---------------------------------------------------------------------------
  // RAM drive: all controls are zero whenever nothing is granted.
  // ---------------------------------------------------------------------------
  assign mem_en    = grant_d || grant_if;
  assign mem_wdata = grant_store ? d_wdata : '0;

  // Selected address: data port first, then fetch, else zero
  always_comb begin
    mem_addr = '0;
    if (grant_d) begin
      mem_addr = d_addr;
    end else if (grant_if) begin
      mem_addr = if_addr;
    end
  end

  // Per-lane write enables, only for a granted store
  genvar gi;
  generate
    for (gi = 0; gi < BE_WIDTH; gi++) begin : g_we_lane
      assign mem_we[gi] = grant_store && d_be[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state: owner, pending flags, store marker and burst counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_next   = OWN_NONE;
    if_pend_next = if_pend_reg;
    d_pend_next  = d_pend_reg;
    store_next   = 1'b0;
    burst_next   = burst_reg;

    if (grant_d) begin
      owner_next = OWN_DATA;
      store_next = d_we;
    end else if (grant_if) begin
      owner_next = OWN_IF;
    end

    // Pending is set on grant, cleared on ack; a same-cycle grant wins
    if (grant_if) begin
      if_pend_next = 1'b1;
    end else if (if_ack) begin
      if_pend_next = 1'b0;
    end

    if (grant_d) begin
      d_pend_next = 1'b1;
    end else if (d_ack) begin
      d_pend_next = 1'b0;
    end

    // Count data grants that overtook a waiting fetch, saturating at the limit
    if (!if_req || grant_if) begin
      burst_next = 4'd0;
    end else if (grant_d && (burst_reg != BURST_MAX)) begin
      burst_next = burst_reg + 4'd1;
    end
  end

  // State registers; reset abandons any in-flight access so no ack follows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_reg   <= OWN_NONE;
      if_pend_reg <= 1'b0;
      d_pend_reg  <= 1'b0;
      store_reg   <= 1'b0;
      burst_reg   <= 4'd0;
    end else begin
      owner_reg   <= owner_next;
      if_pend_reg <= if_pend_next;
      d_pend_reg  <= d_pend_next;
      store_reg   <= store_next;
      burst_reg   <= burst_next;
    end
  end

`ifdef MEM_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Fetch stall statistics: cycles with a fetch request but no fetch grant.
  // ---------------------------------------------------------------------------
  logic [31:0] stall_reg, stall_next;

  // Saturating increment of the stall count
  always_comb begin
    stall_next = stall_reg;
    if (if_req && !grant_if && (stall_reg != 32'hFFFF_FFFF)) begin
      stall_next = stall_reg + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_reg <= 32'd0;
    end else begin
      stall_reg <= stall_next;
    end
  end

  assign stat_if_stall = stall_reg;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural single-port RAM, scoreboard queues of
// expected read data per port, and a negedge monitor that pops and compares
// on every acknowledge.
`timescale 1ns/100ps
module tb_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]   stat_if_stall;
`endif

  mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_DATA_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_ack(if_ack),
    .if_rdata(if_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_be(d_be),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ack(d_ack),
    .d_rdata(d_rdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_if_stall(stat_if_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] if_q[$];
  logic [DW-1:0] d_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  // Behavioural RAM: registered read, byte-lane writes, preload while ram_load
  logic [DW-1:0] ram [0:511];
  logic          ram_load;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 512; i++) ram[i] <= init_word(i);
      ram[9'h010] <= 32'h2008_0005;
      ram[9'h030] <= 32'h1122_3344;
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < BW; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Monitor: compare ack data against the scoreboard, idle outputs against zero
  logic [DW-1:0] exp_if, exp_d;
  always @(negedge clk) begin
    if (if_ack) begin
      if (if_q.size() == 0) chk("if_ack_unexpected", 32'd1, 32'd0);
      else begin
        exp_if = if_q.pop_front();
        chk("if_rdata", if_rdata, exp_if);
        $display("fetch ack  data=0x%08h", if_rdata);
      end
    end else chk("if_rdata_idle", if_rdata, 32'd0);
    if (d_ack) begin
      if (d_q.size() == 0) chk("d_ack_unexpected", 32'd1, 32'd0);
      else begin
        exp_d = d_q.pop_front();
        chk("d_rdata", d_rdata, exp_d);
        $display("data  ack  data=0x%08h", d_rdata);
      end
    end else chk("d_rdata_idle", d_rdata, 32'd0);
    if (!mem_en) begin
      chk("mem_we_idle", 32'(mem_we), 32'd0);
      chk("mem_addr_idle", 32'(mem_addr), 32'd0);
      chk("mem_wdata_idle", mem_wdata, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_if_ack(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!if_ack && n < 50);
    chk(tag, 32'(if_ack), 32'd1);
  endtask

  task automatic wait_d_ack(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!d_ack && n < 50);
    chk(tag, 32'(d_ack), 32'd1);
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    d_we = 1'b0; d_be = '0; d_wdata = '0; d_addr = a; d_req = 1'b1;
    d_q.push_back(exp);
    wait_d_ack("load_ack");
    d_req = 1'b0;
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] w, input logic [BW-1:0] be);
    d_we = 1'b1; d_be = be; d_wdata = w; d_addr = a; d_req = 1'b1;
    d_q.push_back('0);
    wait_d_ack("store_ack");
    d_req = 1'b0; d_we = 1'b0;
  endtask

  // Global bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nsent, nacked, ngrant, cyc;
    logic [31:0] code;
    rst = 1'b1; ram_load = 1'b1;
    if_req = 1'b1; if_addr = 9'h010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h005; d_be = '0; d_wdata = '0;

    // 1: reset held with both requests
    tick(); ram_load = 1'b0; tick(); tick();
    @(negedge clk);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    d_q.push_back(init_word(5));
    if_q.push_back(32'h2008_0005);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_mem_en", 32'(mem_en), 32'd1);
    chk("rel_first_addr", 32'(mem_addr), 32'h005);
    wait_d_ack("rel_d_ack"); d_req = 1'b0;
    wait_if_ack("rel_if_ack"); if_req = 1'b0;

    // 2: single fetch
    tick();
    if_addr = 9'h010; if_req = 1'b1; if_q.push_back(32'h2008_0005);
    @(negedge clk);
    chk("s2_mem_en", 32'(mem_en), 32'd1);
    chk("s2_mem_addr", 32'(mem_addr), 32'h010);
    chk("s2_mem_we", 32'(mem_we), 32'd0);
    wait_if_ack("s2_if_ack"); if_req = 1'b0;

    // 3: store and fetch raised together
    tick();
    d_we = 1'b1; d_addr = 9'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF; d_req = 1'b1;
    if_addr = 9'h020; if_req = 1'b1;
    d_q.push_back('0); if_q.push_back(init_word(9'h020));
    @(negedge clk);
    chk("s3_store_addr", 32'(mem_addr), 32'h100);
    chk("s3_store_we", 32'(mem_we), 32'hF);
    chk("s3_store_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("s3_d_ack", 32'(d_ack), 32'd1);
    chk("s3_if_ack_early", 32'(if_ack), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("s3_fetch_addr", 32'(mem_addr), 32'h020);
    chk("s3_fetch_we", 32'(mem_we), 32'd0);
    tick();
    chk("s3_if_ack", 32'(if_ack), 32'd1);
    if_req = 1'b0;
    do_load(9'h100, 32'hDEAD_BEEF);

    // 4: byte-lane store, then an all-lanes-off store
    do_store(9'h030, 32'h0000_AB00, 4'b0010);
    do_load(9'h030, 32'h1122_AB44);
    do_store(9'h030, 32'hFFFF_FFFF, 4'b0000);
    do_load(9'h030, 32'h1122_AB44);

    // 5: starvation bound with continuous loads and a waiting fetch
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    if_addr = 9'h040; if_req = 1'b1; if_q.push_back(init_word(9'h040));
    d_we = 1'b0; d_be = '0; d_addr = 9'h080; d_req = 1'b1; d_q.push_back(init_word(9'h080));
    nsent = 1; nacked = 0; ngrant = 0; cyc = 0;
    while (nacked < 12 && cyc < 60) begin
      @(negedge clk);
      if (ngrant < 13) begin
        code = !mem_en ? 32'd0 : ((mem_addr == 9'h040) ? 32'd2 : 32'd1);
        chk($sformatf("s5_grant%0d", ngrant), code, (ngrant == 4) ? 32'd2 : 32'd1);
        ngrant++;
      end
      tick(); cyc++;
      if (if_ack) begin
`ifdef MEM_ARB_STATS_EN
        chk("s5_stat_if_stall", stat_if_stall, 32'd4);
`endif
        if_req = 1'b0;
      end
      if (d_ack) begin
        nacked++;
        if (nsent < 12) begin
          d_addr = AW'(32'h080 + nsent);
          d_q.push_back(init_word(32'h080 + nsent));
          nsent++;
        end else d_req = 1'b0;
      end
    end
    chk("s5_loads", 32'(nacked), 32'd12);

    // 6: reset pulse in the ack cycle of a fetch
    tick();
    if_addr = 9'h050; if_req = 1'b1; if_q.push_back(init_word(9'h050));
    @(negedge clk);
    chk("s6_grant", 32'(mem_en), 32'd1);
    @(posedge clk);
    #0.5 rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("s6_no_ack", 32'(if_ack), 32'd0);
    chk("s6_reissue", 32'(mem_en), 32'd1);
    wait_if_ack("s6_if_ack"); if_req = 1'b0;

    tick(); tick();
    chk("if_q_empty", 32'(if_q.size()), 32'd0);
    chk("d_q_empty", 32'(d_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
